debounce_multi: RTL

//  NCH-channel switch/button debouncer with input synchroniser and shared sample strobe.

---
 rtl/debounce_pkg.sv | 22 ++
 rtl/debounce_multi_if.sv | 34 +++
 rtl/debounce_chan.sv | 114 +++++++++++
 rtl/debounce_multi.sv | 61 ++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared types for the multi-channel debouncer.
//   The state encoding is fixed: ZERO=00, WAIT0=01, ONE=10, WAIT1=11.
//   With this encoding the debounced level is simply the XOR of the two state
//   bits. It is 1 in ONE/WAIT0 and 0 in ZERO/WAIT1.
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_ZERO  = 2'b00,
        ST_WAIT0 = 2'b01,
        ST_ONE   = 2'b10,
        ST_WAIT1 = 2'b11
    } db_state_t;

    // Debounced level seen by software for a given state.
    function automatic logic level_of(input db_state_t st);
        return st[1] ^ st[0];
    endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// -----------------------------------------------------------------------------
// debounce_multi_if
//   Bundles the sample strobe, the raw switch inputs and the debounced results.
//   master : drives sample_en/sw and observes the results (board side / bench)
//   slave  : the debouncer itself
// -----------------------------------------------------------------------------
interface debounce_multi_if #(
    parameter int NCH = 4
);
    logic           sample_en;
    logic [NCH-1:0] sw;
    logic [NCH-1:0] db_level;
    logic [NCH-1:0] rise_tick;
    logic [NCH-1:0] fall_tick;
    logic           any_tick;

    modport master (
        output sample_en,
        output sw,
        input  db_level,
        input  rise_tick,
        input  fall_tick,
        input  any_tick
    );

    modport slave (
        input  sample_en,
        input  sw,
        output db_level,
        output rise_tick,
        output fall_tick,
        output any_tick
    );
endinterface

// File: rtl/debounce_chan.sv
// -----------------------------------------------------------------------------
// debounce_chan
//   One debouncer channel. It contains a synchroniser chain, a 4-state FSM, an
//   N-bit down-counter, and the level and tick registers.
//   Ports:
//     clk, reset_n   clock, async active-low reset
//     sample_en      FSM/counter advance only when 1 (sync chain always clocks)
//     sw             raw asynchronous input
//     db_level       debounced level (decoded from the state register)
//     rise_tick      1-cycle registered pulse on the 0->1 transition
//     fall_tick      1-cycle registered pulse on the 1->0 transition
//     tick_nxt       value rise_tick|fall_tick will take after the next edge,
//                    so the top can register any_tick in the same cycle
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   ZERO  | stable low
//   WAIT1 | input high, counting samples before declaring high
//   ONE   | stable high
//   WAIT0 | input low, counting samples before declaring low
// -----------------------------------------------------------------------------
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int   N           = 20,
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT        = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_en,
    input  logic sw,
    output logic db_level,
    output logic rise_tick,
    output logic fall_tick,
    output logic tick_nxt
);

    localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_t              state_q;
    logic [N-1:0]           cnt_q;
    logic                   rise_nxt;
    logic                   fall_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{INIT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // The exit happens on the sample where the counter would reach zero.
    assign rise_nxt = sample_en && (state_q == ST_WAIT1) &&  s && (cnt_q == CNT_ONE);
    assign fall_nxt = sample_en && (state_q == ST_WAIT0) && !s && (cnt_q == CNT_ONE);
    assign tick_nxt = rise_nxt | fall_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= INIT ? ST_ONE : ST_ZERO;
            cnt_q     <= '0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            rise_tick <= rise_nxt;
            fall_tick <= fall_nxt;
            if (sample_en) begin
                case (state_q)
                    ST_ZERO: begin
                        if (s) begin
                            state_q <= ST_WAIT1;
                            cnt_q   <= '1;
                        end
                    end
                    ST_WAIT1: begin
                        if (!s) begin
                            state_q <= ST_ZERO;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                            if (cnt_q == CNT_ONE) begin
                                state_q <= ST_ONE;
                            end
                        end
                    end
                    ST_ONE: begin
                        if (!s) begin
                            state_q <= ST_WAIT0;
                            cnt_q   <= '1;
                        end
                    end
                    ST_WAIT0: begin
                        if (s) begin
                            state_q <= ST_ONE;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                            if (cnt_q == CNT_ONE) begin
                                state_q <= ST_ZERO;
                            end
                        end
                    end
                    default: state_q <= ST_ZERO;
                endcase
            end
        end
    end

    assign db_level = level_of(state_q);

endmodule

// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
//   NCH independent switch debouncers that share one sample strobe.
//   Ports:
//     clk, reset_n   clock, async active-low reset
//     bus (slave)    sample_en, sw[NCH] in; db_level, rise_tick, fall_tick
//                    [NCH] and any_tick out
//   Stable window = 2^N accepted samples after SYNC_STAGES sync flops.
// -----------------------------------------------------------------------------
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int             NCH         = 4,
    parameter int             N           = 20,
    parameter int             SYNC_STAGES = 2,
    parameter logic [NCH-1:0] INIT_LEVEL  = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    debounce_multi_if.slave bus
);

    logic [NCH-1:0] level_w;
    logic [NCH-1:0] rise_w;
    logic [NCH-1:0] fall_w;
    logic [NCH-1:0] nxt_w;
    logic           any_q;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        debounce_chan #(
            .N           (N),
            .SYNC_STAGES (SYNC_STAGES),
            .INIT        (INIT_LEVEL[i])
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .sample_en (bus.sample_en),
            .sw        (bus.sw[i]),
            .db_level  (level_w[i]),
            .rise_tick (rise_w[i]),
            .fall_tick (fall_w[i]),
            .tick_nxt  (nxt_w[i])
        );
    end

    // Registered from the channels' next-tick values so that any_tick lines up
    // with the per-channel ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |nxt_w;
        end
    end

    assign bus.db_level  = level_w;
    assign bus.rise_tick = rise_w;
    assign bus.fall_tick = fall_w;
    assign bus.any_tick  = any_q;

endmodule
